// File: rtl/pingpong_buf_sched.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_buf_sched
// Description : Hands the ping-pong buffer banks to the LOAD, COMPUTE and
//               STORE stages in strict bank order. Every bank cycles through
//               FREE -> LOADING -> LOADED -> COMPUTING -> COMPUTED ->
//               STORING -> FREE. A stage cannot obtain a bank until the
//               previous stage has released it.
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_buf_sched #(
    parameter int BANK_NUM = 2,
    parameter int BANK_W   = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req,
    output logic                  ld_gnt,
    output logic [BANK_W-1:0]     ld_bank,
    input  logic                  ld_done,
    input  logic                  cp_req,
    output logic                  cp_gnt,
    output logic [BANK_W-1:0]     cp_bank,
    input  logic                  cp_done,
    input  logic                  st_req,
    output logic                  st_gnt,
    output logic [BANK_W-1:0]     st_bank,
    input  logic                  st_done,
    output logic                  busy,
    output logic                  err,
    output logic [BANK_NUM*3-1:0] bank_state
);

    // Per-bank state codes
    localparam logic [2:0] c_FREE      = 3'd0;
    localparam logic [2:0] c_LOADING   = 3'd1;
    localparam logic [2:0] c_LOADED    = 3'd2;
    localparam logic [2:0] c_COMPUTING = 3'd3;
    localparam logic [2:0] c_COMPUTED  = 3'd4;
    localparam logic [2:0] c_STORING   = 3'd5;

    // Per-stage FSM states
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_OWN  = 2'd2;

    // Stage index 0 = LOAD, 1 = COMPUTE, 2 = STORE; tables are packed per stage
    localparam int         c_NSTG    = 3;
    localparam logic [8:0] c_NEED    = {c_COMPUTED, c_LOADED,    c_FREE};
    localparam logic [8:0] c_CLAIM   = {c_STORING,  c_COMPUTING, c_LOADING};
    localparam logic [8:0] c_RELEASE = {c_FREE,     c_COMPUTED,  c_LOADED};
    localparam logic [BANK_W-1:0] c_LAST = BANK_W'(BANK_NUM - 1);

    logic [c_NSTG-1:0]        w_req;
    logic [c_NSTG-1:0]        w_done;
    logic [c_NSTG-1:0]        w_claim;
    logic [c_NSTG-1:0]        w_rel;
    logic [c_NSTG-1:0]        w_perr;
    logic [c_NSTG-1:0]        w_active;
    logic [c_NSTG-1:0]        w_gnt;
    logic [c_NSTG*BANK_W-1:0] w_ptr;
    logic [c_NSTG*BANK_W-1:0] w_own;

    logic [BANK_NUM*3-1:0]    bank_q;
    logic [BANK_NUM*3-1:0]    bank_d;
    logic                     err_q;
    logic                     err_d;

    assign w_req  = {st_req,  cp_req,  ld_req};
    assign w_done = {st_done, cp_done, ld_done};

    for (genvar s = 0; s < c_NSTG; s++) begin : g_stage
        logic [1:0]        stg_q, stg_d;
        logic [BANK_W-1:0] ptr_q, ptr_d;
        logic [BANK_W-1:0] own_q, own_d;
        logic              gnt_q, gnt_d;
        logic              claim, rel, perr;

        // Stage FSM: wait for the next bank in order to reach the required state
        always_comb begin
            stg_d = stg_q;
            ptr_d = ptr_q;
            own_d = own_q;
            gnt_d = 1'b0;
            claim = 1'b0;
            rel   = 1'b0;
            case (stg_q)
                c_IDLE: begin
                    if (w_req[s]) begin
                        stg_d = c_WAIT;
                    end
                end
                c_WAIT: begin
                    // request is latched here even if req is dropped
                    if (bank_q[int'(ptr_q)*3 +: 3] == c_NEED[s*3 +: 3]) begin
                        stg_d = c_OWN;
                        gnt_d = 1'b1;
                        own_d = ptr_q;
                        claim = 1'b1;
                    end
                end
                c_OWN: begin
                    if (w_done[s]) begin
                        stg_d = c_IDLE;
                        rel   = 1'b1;
                        ptr_d = (ptr_q == c_LAST) ? '0 : ptr_q + 1'b1;
                    end
                end
                default: stg_d = c_IDLE;
            endcase
            // done outside OWN, or req while owning, is a protocol violation
            perr = (w_done[s] && (stg_q != c_OWN)) || (w_req[s] && (stg_q == c_OWN));
        end

        // Stage registers
        always_ff @(posedge clk) begin
            if (rst) begin
                stg_q <= c_IDLE;
                ptr_q <= '0;
                own_q <= '0;
                gnt_q <= 1'b0;
            end else begin
                stg_q <= stg_d;
                ptr_q <= ptr_d;
                own_q <= own_d;
                gnt_q <= gnt_d;
            end
        end

        assign w_claim[s]                 = claim;
        assign w_rel[s]                   = rel;
        assign w_perr[s]                  = perr;
        assign w_active[s]                = (stg_q != c_IDLE);
        assign w_gnt[s]                   = gnt_q;
        assign w_ptr[s*BANK_W +: BANK_W]  = ptr_q;
        assign w_own[s*BANK_W +: BANK_W]  = own_q;
    end

    // Bank next state: claims first, releases last so a release wins a collision
    always_comb begin
        bank_d = bank_q;
        for (int s = 0; s < c_NSTG; s++) begin
            if (w_claim[s]) begin
                bank_d[int'(w_ptr[s*BANK_W +: BANK_W])*3 +: 3] = c_CLAIM[s*3 +: 3];
            end
        end
        for (int s = 0; s < c_NSTG; s++) begin
            if (w_rel[s]) begin
                bank_d[int'(w_own[s*BANK_W +: BANK_W])*3 +: 3] = c_RELEASE[s*3 +: 3];
            end
        end
        err_d = err_q | (|w_perr);
    end

    // Bank state and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
            err_q  <= 1'b0;
        end else begin
            bank_q <= bank_d;
            err_q  <= err_d;
        end
    end

    // Busy is derived from registered state only
    always_comb begin
        busy = |w_active;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (bank_q[b*3 +: 3] != c_FREE) begin
                busy = 1'b1;
            end
        end
    end

    assign ld_gnt     = w_gnt[0];
    assign cp_gnt     = w_gnt[1];
    assign st_gnt     = w_gnt[2];
    assign ld_bank    = w_own[0 +: BANK_W];
    assign cp_bank    = w_own[BANK_W +: BANK_W];
    assign st_bank    = w_own[2*BANK_W +: BANK_W];
    assign err        = err_q;
    assign bank_state = bank_q;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_buf_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pingpong_buf_sched
// Description : Scoreboard bench for pingpong_buf_sched. Instance A uses two
//               banks, instance B three banks. Stage index 0..2 maps to
//               A's LOAD/COMPUTE/STORE and 3..5 to B's.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_buf_sched;

    typedef struct {
        int cyc;
        int bank;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] req;
    logic [5:0] done;
    logic [2:0] a_gnt;
    logic [2:0] b_gnt;
    logic [5:0] gnt;
    logic [0:0] a_bk [3];
    logic [1:0] b_bk [3];
    logic       a_busy, a_err, b_busy, b_err;
    logic [5:0] a_bs;
    logic [8:0] b_bs;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   base;
    exp_t exp_q [6][$];
    exp_t mon_e;
    int   t4_seq [7] = '{0, 1, 2, 0, 1, 2, 0};

    assign gnt = {b_gnt, a_gnt};

    always #5 clk = ~clk;

    pingpong_buf_sched #(.BANK_NUM(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .ld_req(req[0]), .ld_gnt(a_gnt[0]), .ld_bank(a_bk[0]), .ld_done(done[0]),
        .cp_req(req[1]), .cp_gnt(a_gnt[1]), .cp_bank(a_bk[1]), .cp_done(done[1]),
        .st_req(req[2]), .st_gnt(a_gnt[2]), .st_bank(a_bk[2]), .st_done(done[2]),
        .busy(a_busy), .err(a_err), .bank_state(a_bs)
    );

    pingpong_buf_sched #(.BANK_NUM(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .ld_req(req[3]), .ld_gnt(b_gnt[0]), .ld_bank(b_bk[0]), .ld_done(done[3]),
        .cp_req(req[4]), .cp_gnt(b_gnt[1]), .cp_bank(b_bk[1]), .cp_done(done[4]),
        .st_req(req[5]), .st_gnt(b_gnt[2]), .st_bank(b_bk[2]), .st_done(done[5]),
        .busy(b_busy), .err(b_err), .bank_state(b_bs)
    );

    function automatic int get_bank(int idx);
        if (idx < 3) return int'(a_bk[idx]);
        return int'(b_bk[idx-3]);
    endfunction

    function automatic void chk(string nm, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req  = '0;
        done = '0;
        rst  = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
    endtask

    // Request a bank and wait (bounded) for its grant; req drops once granted
    task automatic gg(input int idx, input int bank);
        int n;
        exp_q[idx].push_back('{-1, bank});
        req[idx] = 1'b1;
        n = 0;
        while (!gnt[idx] && n < 30) begin
            tick();
            n++;
        end
        if (!gnt[idx]) begin
            chk($sformatf("grant_timeout s%0d", idx), 0, 1);
            void'(exp_q[idx].pop_back());
        end
        req[idx] = 1'b0;
    endtask

    task automatic rel(input int idx);
        done[idx] = 1'b1;
        tick();
        done[idx] = 1'b0;
    endtask

    // Cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: every grant pops the scoreboard entry for its stage
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (gnt[i]) begin
                    if (exp_q[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_gnt s%0d: got bank %0d required no grant", i, get_bank(i));
                    end else begin
                        mon_e = exp_q[i].pop_front();
                        chk($sformatf("gnt_bank s%0d", i), get_bank(i), mon_e.bank);
                        if (mon_e.cyc >= 0) chk($sformatf("gnt_cycle s%0d", i), cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req  = '0;
        done = '0;
        rst  = 1'b1;
        do_reset();

        // Reset state
        chk("rst_bank_state", int'(a_bs), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_err", int'(a_err), 0);
        chk("rst_gnt", int'(a_gnt), 0);
        chk("rst_ld_bank", get_bank(0), 0);

        // 1: full pipeline on bank 0 with exact latencies
        base = cyc;
        exp_q[0].push_back('{base + 2, 0});
        exp_q[1].push_back('{base + 7, 0});
        exp_q[2].push_back('{base + 12, 0});
        req[2:0] = 3'b111;
        for (int k = 0; k <= 16; k++) begin
            for (int s = 0; s < 3; s++) if (gnt[s]) req[s] = 1'b0;
            done[0] = (k == 5);
            done[1] = (k == 10);
            done[2] = (k == 15);
            if (k == 3)  chk("t1_busy", int'(a_busy), 1);
            if (k == 6)  chk("t1_bank0_loaded", int'(a_bs[2:0]), 2);
            if (k == 11) chk("t1_bank0_computed", int'(a_bs[2:0]), 4);
            if (k == 16) begin
                chk("t1_bank_free", int'(a_bs), 0);
                chk("t1_busy_end", int'(a_busy), 0);
                chk("t1_err", int'(a_err), 0);
            end
            tick();
        end
        done = '0;
        req  = '0;

        // 2: two loads fill both banks; third load stalls
        do_reset();
        gg(0, 0);
        rel(0);
        gg(0, 1);
        rel(0);
        req[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 19) chk("t2_no_gnt", int'(a_gnt[0]), 0);
        end
        chk("t2_bank_state", int'(a_bs), 6'b010_010);
        chk("t2_busy", int'(a_busy), 1);
        req[0] = 1'b0;

        // 3: LOAD on bank 1 while COMPUTE owns bank 0, simultaneous done
        do_reset();
        gg(0, 0);
        rel(0);
        gg(1, 0);
        gg(0, 1);
        done[0] = 1'b1;
        done[1] = 1'b1;
        tick();
        done = '0;
        chk("t3_bank_state", int'(a_bs), 6'b010_100);
        chk("t3_err", int'(a_err), 0);

        // 5: done while COMPUTE is idle
        rel(1);
        chk("t5_err_set", int'(a_err), 1);
        chk("t5_bank_state", int'(a_bs), 6'b010_100);
        tick();
        tick();
        chk("t5_err_sticky", int'(a_err), 1);

        // 6: reset while LOAD owns bank 0 and bank 1 is loaded
        do_reset();
        gg(0, 0); rel(0);
        gg(1, 0); rel(1);
        gg(2, 0); rel(2);
        gg(0, 1); rel(0);
        gg(0, 0);
        chk("t6_pre_state", int'(a_bs), 6'b010_001);
        rel(2);
        chk("t6_pre_err", int'(a_err), 1);
        rst = 1'b1;
        tick();
        chk("t6_bank_state", int'(a_bs), 0);
        chk("t6_busy", int'(a_busy), 0);
        chk("t6_err", int'(a_err), 0);
        rst = 1'b0;
        gg(0, 0);
        rel(0);

        // 4: three banks, seven pipeline iterations
        do_reset();
        for (int i = 0; i < 7; i++) begin
            gg(3, t4_seq[i]); rel(3);
            gg(4, t4_seq[i]); rel(4);
            gg(5, t4_seq[i]); rel(5);
            chk($sformatf("t4_err it%0d", i), int'(b_err), 0);
        end
        chk("t4_bank_state", int'(b_bs), 0);
        chk("t4_busy", int'(b_busy), 0);

        tick();
        for (int i = 0; i < 6; i++) chk($sformatf("leftover s%0d", i), exp_q[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
